// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC SPI responder.
package adc_pkg;

  localparam int unsigned ADC_FRAME_LEN  = 16;
  localparam int unsigned ADC_ADDR_FIRST = 3;
  localparam int unsigned ADC_ADDR_LAST  = 5;
  localparam int unsigned ADC_DATA_FIRST = 4;

  typedef enum logic {StIdle, StActive} adc_state_e;

  typedef logic [2:0] adc_addr_t;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI input, with rise/fall detection
// against the previous synchronized sample.
module spi_in_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < int'(STAGES); i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/adc_spi_responder.sv
// Emulates an 8-channel 12-bit serial ADC (ADC128S022 framing) on the far end of the SPI bus.
// Define ADC_RESP_FRAME_CHECK_EN to build the framing-error flag and aborted-frame counter.
module adc_spi_responder
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_spi_sclk,
  input  logic                     i_spi_cs,
  input  logic                     i_spi_din,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
  output logic                     o_spi_dout,
  output logic                     o_frame_done,
  output adc_addr_t                o_cur_addr,
  output logic                     o_frame_err,
  output logic [7:0]               o_err_cnt
);

  localparam logic [4:0] K_LAST       = 5'(ADC_FRAME_LEN);
  localparam logic [4:0] K_ADDR_FIRST = 5'(ADC_ADDR_FIRST);
  localparam logic [4:0] K_ADDR_LAST  = 5'(ADC_ADDR_LAST);
  localparam logic [4:0] K_DATA_FIRST = 5'(ADC_DATA_FIRST);

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_din_sync;
  logic w_unused_sclk_lvl, w_unused_cs_lvl, w_unused_din_rise, w_unused_din_fall;

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_spi_sclk),
    .o_sync  (w_unused_sclk_lvl),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_spi_cs),
    .o_sync  (w_unused_cs_lvl),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_spi_din),
    .o_sync  (w_din_sync),
    .o_rise  (w_unused_din_rise),
    .o_fall  (w_unused_din_fall)
  );

  adc_state_e        r_state, w_state_nxt;
  logic [4:0]        r_k;
  logic [4:0]        w_k_inc;
  adc_addr_t         r_addr_nxt, r_cur_addr;
  logic [DATA_W-1:0] r_shift, w_sel;
  logic              r_dout, r_frame_done;
  logic              w_abort, w_rise_act, w_fall_act;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_cs_fall) w_state_nxt = StActive;
      StActive: if (w_cs_rise) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // cs rising takes priority over any sclk edge seen in the same sample
  assign w_abort    = (r_state == StActive) && w_cs_rise;
  assign w_rise_act = (r_state == StActive) && !w_cs_rise && w_sclk_rise;
  assign w_fall_act = (r_state == StActive) && !w_cs_rise && w_sclk_fall;
  assign w_k_inc    = r_k + 5'd1;

  always_comb begin
    w_sel = '0;
    for (int n = 0; n < int'(NUM_CH); n++) begin
      if (r_cur_addr == adc_addr_t'(n)) w_sel = i_ch_data[n*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k          <= '0;
      r_addr_nxt   <= '0;
      r_cur_addr   <= '0;
      r_shift      <= '0;
      r_dout       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_abort) begin
        r_k     <= '0;
        r_shift <= '0;
        r_dout  <= 1'b0;
      end else if (w_rise_act) begin
        if (w_k_inc >= K_ADDR_FIRST && w_k_inc <= K_ADDR_LAST) begin
          r_addr_nxt <= {r_addr_nxt[1:0], w_din_sync};
        end
        if (w_k_inc == K_LAST) begin
          r_k          <= '0;
          r_cur_addr   <= r_addr_nxt;
          r_frame_done <= 1'b1;
        end else begin
          r_k <= w_k_inc;
        end
      end else if (w_fall_act) begin
        if (r_k == K_DATA_FIRST) begin
          r_shift <= w_sel;
          r_dout  <= w_sel[DATA_W-1];
        end else if (r_k > K_DATA_FIRST && r_k < K_LAST) begin
          r_shift <= {r_shift[DATA_W-2:0], 1'b0};
          r_dout  <= r_shift[DATA_W-2];
        end else begin
          // k wrapped to 0 after edge 16: frame tail, line goes quiet
          r_shift <= '0;
          r_dout  <= 1'b0;
        end
      end
    end
  end

  assign o_spi_dout   = r_dout;
  assign o_frame_done = r_frame_done;
  assign o_cur_addr   = r_cur_addr;

`ifdef ADC_RESP_FRAME_CHECK_EN
  logic       r_frame_err;
  logic [7:0] r_err_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_err <= 1'b0;
      r_err_cnt   <= '0;
    end else if (w_abort && r_k != '0 && r_k != K_LAST) begin
      r_frame_err <= 1'b1;
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_frame_err = r_frame_err;
  assign o_err_cnt   = r_err_cnt;
`else
  assign o_frame_err = 1'b0;
  assign o_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: bit-banged SPI master plus a frame-level model.
module tb_adc_spi_responder;

  localparam int NCH  = 8;
  localparam int DW   = 12;
  localparam int SS   = 2;
  localparam int HALF = 8;

  logic              clk = 1'b0;
  logic              rst_n, sclk, cs, din;
  logic [NCH*DW-1:0] ch_data;
  logic              dout, done, ferr;
  logic [2:0]        cur;
  logic [7:0]        ecnt;

  adc_spi_responder #(.NUM_CH(NCH), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_spi_sclk   (sclk),
    .i_spi_cs     (cs),
    .i_spi_din    (din),
    .i_ch_data    (ch_data),
    .o_spi_dout   (dout),
    .o_frame_done (done),
    .o_cur_addr   (cur),
    .o_frame_err  (ferr),
    .o_err_cnt    (ecnt)
  );

  always #5 clk = ~clk;

  int         n_pass = 0;
  int         n_tot  = 0;
  logic [2:0] m_cur  = '0;
  int         m_err  = 0;
  bit         chk_en;
  logic [2:0] done_q[$];
  logic [2:0] shown  = '0;
  int         n_done = 0;
  int         cs_hi  = 0;
  bit         prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_ch(input int n, input logic [DW-1:0] v);
    ch_data[n*DW +: DW] = v;
  endtask

  function automatic logic [DW-1:0] get_ch(input logic [2:0] a);
    return ch_data[int'(a)*DW +: DW];
  endfunction

  function automatic logic din_bit(input logic [2:0] addr, input int k);
    if (k == 3) return addr[2];
    if (k == 4) return addr[1];
    if (k == 5) return addr[0];
    return 1'b0;
  endfunction

  // Full 16-edge frame. The word the master should get is whatever the selected channel
  // held when the 4th edge's fall occurred; chg_k optionally rewrites that channel later.
  task automatic frame(input logic [2:0] addr, input bit release_cs, input int chg_k,
                       input logic [DW-1:0] chg_val, output logic [DW-1:0] rx,
                       output logic [DW-1:0] exp);
    logic [DW-1:0] snap;
    snap = '0;
    exp  = '0;
    if (cs) begin
      cs = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    rx = '0;
    for (int k = 1; k <= 16; k++) begin
      sclk = 1'b0;
      din  = din_bit(addr, k);
      if (k == 5) snap = get_ch(m_cur);
      if (k == chg_k) set_ch(int'(m_cur), chg_val);
      repeat (HALF) @(negedge clk);
      if (k >= 5) rx = {rx[DW-2:0], dout};
      sclk = 1'b1;
      if (k == 16) begin
        done_q.push_back(addr);
        exp   = snap;
        m_cur = addr;
      end
      repeat (HALF) @(negedge clk);
    end
    if (release_cs) begin
      cs  = 1'b1;
      din = 1'b0;
      repeat (2*HALF) @(negedge clk);
    end
  endtask

  task automatic partial(input logic [2:0] addr, input int n, input bit release_cs);
    if (cs) begin
      cs = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    for (int k = 1; k <= n; k++) begin
      sclk = 1'b0;
      din  = din_bit(addr, k);
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    if (release_cs) begin
      cs  = 1'b1;
      din = 1'b0;
      if (chk_en && n % 16 != 0) m_err = (m_err == 255) ? 255 : m_err + 1;
    end
    repeat (2*HALF) @(negedge clk);
  endtask

  // Cycle-by-cycle compare: cur_addr may move only on a frame_done pulse, and then only to
  // the address the master sent in the frame that just ended.
  always @(negedge clk) begin
    if (!rst_n) begin
      shown     = '0;
      done_q.delete();
      prev_done = 1'b0;
      cs_hi     = 0;
    end else begin
      if (done) begin
        n_done++;
        chk("frame_done single pulse", {31'b0, prev_done}, 32'd0);
        chk("frame_done pending frames", done_q.size(), 32'd1);
        if (done_q.size() > 0) shown = done_q.pop_front();
      end
      prev_done = done;
      chk("cur_addr vs model", {29'b0, cur}, {29'b0, shown});
      cs_hi = cs ? cs_hi + 1 : 0;
      if (cs_hi > SS + 2) begin
        chk("dout idle", {31'b0, dout}, 32'd0);
        chk("frame_done idle", {31'b0, done}, 32'd0);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tot);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rx, exp;
    int d0;
`ifdef ADC_RESP_FRAME_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    rst_n   = 1'b0;
    sclk    = 1'b1;
    cs      = 1'b1;
    din     = 1'b0;
    ch_data = '0;
    set_ch(0, 12'hA5C);
    repeat (4) @(negedge clk);
    chk("reset dout", {31'b0, dout}, 32'd0);
    chk("reset frame_done", {31'b0, done}, 32'd0);
    chk("reset cur_addr", {29'b0, cur}, 32'd0);
    chk("reset frame_err", {31'b0, ferr}, 32'd0);
    chk("reset err_cnt", {24'b0, ecnt}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // First frame after reset reads channel 0
    frame(3'd0, 1'b1, 0, '0, rx, exp);
    chk("t1 rx model", rx, exp);
    chk("t1 rx literal", rx, 12'hA5C);
    chk("t1 cur_addr", cur, 32'd0);

    // Address takes effect one frame later
    set_ch(3, 12'h123);
    frame(3'd3, 1'b1, 0, '0, rx, exp);
    chk("t2a rx model", rx, exp);
    chk("t2a cur_addr", cur, 32'd3);
    frame(3'd3, 1'b1, 0, '0, rx, exp);
    chk("t2b rx model", rx, exp);
    chk("t2b rx literal", rx, 12'h123);

    // Continuous mode, cs held low across three frames
    set_ch(1, 12'h111);
    set_ch(2, 12'h222);
    set_ch(3, 12'h333);
    d0 = n_done;
    frame(3'd1, 1'b0, 0, '0, rx, exp);
    chk("t3a rx model", rx, exp);
    frame(3'd2, 1'b0, 0, '0, rx, exp);
    chk("t3b rx model", rx, exp);
    chk("t3b rx literal", rx, 12'h111);
    frame(3'd3, 1'b1, 0, '0, rx, exp);
    chk("t3c rx model", rx, exp);
    chk("t3c rx literal", rx, 12'h222);
    chk("t3 frame_done count", n_done - d0, 32'd3);
    chk("t3 cur_addr", cur, 32'd3);

    // Abort after 9 edges: address 5 must not take effect
    d0 = n_done;
    partial(3'd5, 9, 1'b1);
    chk("t4 no frame_done", n_done - d0, 32'd0);
    chk("t4 cur_addr", cur, 32'd3);
    chk("t4 frame_err model", {31'b0, ferr}, (m_err != 0) ? 32'd1 : 32'd0);
    chk("t4 err_cnt model", {24'b0, ecnt}, m_err);
    chk("t4 err_cnt literal", {24'b0, ecnt}, chk_en ? 32'd1 : 32'd0);
    frame(3'd3, 1'b1, 0, '0, rx, exp);
    chk("t4 next rx model", rx, exp);
    chk("t4 next rx literal", rx, 12'h333);

    // ch_data rewritten after the load point
    frame(3'd3, 1'b1, 8, 12'h3C3, rx, exp);
    chk("t5a rx model", rx, exp);
    chk("t5a rx literal", rx, 12'h333);
    frame(3'd3, 1'b1, 0, '0, rx, exp);
    chk("t5b rx model", rx, exp);
    chk("t5b rx literal", rx, 12'h3C3);

    // Reset in the middle of a frame
    partial(3'd6, 7, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6 rst dout", {31'b0, dout}, 32'd0);
    chk("t6 rst frame_done", {31'b0, done}, 32'd0);
    chk("t6 rst cur_addr", {29'b0, cur}, 32'd0);
    chk("t6 rst frame_err", {31'b0, ferr}, 32'd0);
    chk("t6 rst err_cnt", {24'b0, ecnt}, 32'd0);
    m_cur = '0;
    m_err = 0;
    repeat (2) @(negedge clk);
    cs   = 1'b1;
    sclk = 1'b1;
    din  = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    frame(3'd5, 1'b1, 0, '0, rx, exp);
    chk("t6 rx model", rx, exp);
    chk("t6 rx literal", rx, 12'hA5C);
    chk("t6 cur_addr", cur, 32'd5);

    chk("end pending frames", done_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
